seg7_capture: RTL and testbench
===============================

// Module: seg7_capture
// PURPOSE
//   Receive side of the 7-segment display bus. Samples an external 7-segment pattern
//   (active-high, bit0=a .. bit6=g) and debounces it. Decodes each stable pattern back
//   to a 4-bit hex digit, reported with a one-cycle valid strobe.
//   Also flags blank, illegal and out-of-sequence patterns, so a counting display can be
//   checked on silicon from a second tile or from the test harness.
// PARAMETERS
//   STABLE_CYCLES  4  consecutive identical synchronised samples needed to accept a pattern (>=1)
//   CNT_W          8  width of the accepted-digit counter
// PORTS
//   clk          in   1      system clock
//   rst_n        in   1      asynchronous active-low reset
//   seg_in       in   7      raw segment pattern, asynchronous to clk
//   en           in   1      capture enable; low = no acceptance
//   digit        out  4      last accepted decoded hex digit (held)
//   digit_valid  out  1      1-cycle pulse: new legal digit accepted
//   bad_pattern  out  1      1-cycle pulse: accepted pattern not in table and not 0x00
//   seq_err      out  1      1-cycle pulse with digit_valid: digit != previous digit + 1 (mod 16)
//   blank        out  1      level: last accepted pattern was 0x00
//   cap_count    out  CNT_W  number of digit_valid pulses since reset, wraps mod 2^CNT_W
// BEHAVIOUR
//   - Reset (async assert, sync release): digit=0, digit_valid=0, bad_pattern=0, seq_err=0,
//     blank=1, cap_count=0, last_accepted=7'h00, have_prev=0, sync flops=0, stab_cnt=0.
//   - Synchroniser: seg_in -> q1 -> q2, two flops. Always runs, regardless of en.
//   - Stability: candidate register plus stab_cnt (width clog2(STABLE_CYCLES+1)).
//     - q2 != candidate: candidate<=q2, stab_cnt<=1.
//     - q2 == candidate and stab_cnt<STABLE_CYCLES: stab_cnt increments; saturates at STABLE_CYCLES.
//     - en=0: stab_cnt held at 0. Counting restarts once en returns high.
//   - Acceptance fires once, on the cycle stab_cnt reaches STABLE_CYCLES with candidate != last_accepted.
//     It sets last_accepted<=candidate. Outputs are registered on the following edge.
//   - Latency: let E be the first edge sampling a new seg_in. The result pulse is registered
//     on edge E+STABLE_CYCLES+2 (E+6 at default).
//   - Glitches shorter than STABLE_CYCLES are never accepted. Returning to the already
//     accepted pattern reports nothing.
//   - Classification of an accepted pattern:
//     - legal hex (table below): digit<=decoded, digit_valid pulse, blank<=0, cap_count++.
//       seq_err pulses iff have_prev=1 and decoded != digit+1 mod 16. F->0 is legal.
//       Then have_prev<=1.
//     - 0x00: blank<=1, have_prev<=0. No pulse; digit and cap_count unchanged.
//     - any other value: bad_pattern pulse, blank<=0, have_prev<=0. digit unchanged.
//   - At most one of digit_valid/bad_pattern is high in any cycle. Each is high for exactly one cycle.
//   - Segment table (hex->pattern):
//     0:3F  1:06  2:5B  3:4F  4:66  5:6D  6:7D  7:07
//     8:7F  9:6F  A:77  b:7C  C:39  d:5E  E:79  F:71
//   - Reset asserted mid-debounce or mid-pulse: everything returns to reset values immediately.
//     The first legal digit after release never raises seq_err.
// STRUCTURE
//   - seg7_pkg: 16-entry segment constant table, SEG_BLANK=7'h00, and function seg_to_hex
//     returning {legal, hex[3:0]}. Shared with the display driver's encoder.
//   - Sub-module seg7_decode: combinational pattern -> {legal, hex}, built on the package function.
//   - Top-level holds the synchroniser, stability counter, classifier and output registers.
// TESTING
//   1. Reset then seg_in=7'h3F held, en=1 -> digit_valid single pulse on edge E+6, digit=0,
//      blank=0, cap_count=1, seq_err=0.
//   2. Step 0..F then 0 (3F,06,...,71,3F), each held 10 cycles -> 17 digit_valid pulses,
//      cap_count=17, seq_err never asserted (F->0 wrap included).
//   3. Stable 06 (digit 1), then 4F (3) -> digit=3 with seq_err pulse coincident with digit_valid.
//   4. From stable 5B, glitch to 7F for 3 cycles, back to 5B -> no pulses; digit stays 2.
//   5. seg_in=7'h49 for 10 cycles -> bad_pattern single pulse, digit unchanged.
//      Then 00 -> blank=1. Then 66 -> digit_valid, digit=4, no seq_err.
//   6. en=0 while seg_in moves 3F->06 -> no pulses. Raise en -> digit_valid at en-rise edge+5.
//      Assert rst_n=0 mid-hold -> all outputs reset asynchronously.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions (active-high, bit0=a .. bit6=g) used by capture and display encoder.
// Holds the hex glyph table, the blank code and the pattern<->hex conversion helpers.
package seg7_pkg;

  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Index n holds the glyph for hex digit n.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic       legal;
    logic [3:0] hex;
  } seg_dec_t;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_HEX,
    CLS_BLANK,
    CLS_BAD
  } seg_class_t;

  function automatic seg_dec_t seg_to_hex(input logic [SEG_W-1:0] seg);
    seg_dec_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        r.legal = 1'b1;
        r.hex   = 4'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] hex);
    return SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/seg7_capture_decode.sv
// Combinational 7-segment pattern to hex decoder; legal is low for any pattern outside the glyph table.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] i_seg,
  output logic             o_legal,
  output logic [3:0]       o_hex
);

  seg_dec_t w_dec;

  always_comb begin
    w_dec   = seg_to_hex(i_seg);
    o_legal = w_dec.legal;
    o_hex   = w_dec.hex;
  end

endmodule

// File: rtl/seg7_capture.sv
// Synchronises and debounces a 7-segment bus, decodes each newly stable pattern and flags blank/illegal/out-of-order digits.
// Result pulses appear STABLE_CYCLES+2 edges after the first edge that samples a new pattern.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       seg_in,
  input  logic             en,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             bad_pattern,
  output logic             seq_err,
  output logic             blank,
  output logic [CNT_W-1:0] cap_count
);

  localparam int            STAB_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);

  logic [SEG_W-1:0]  r_q1;
  logic [SEG_W-1:0]  r_q2;
  logic [SEG_W-1:0]  r_cand;
  logic [STAB_W-1:0] r_stab;
  logic [SEG_W-1:0]  r_last;
  logic              r_have_prev;

  logic [3:0]        r_digit;
  logic              r_valid;
  logic              r_bad;
  logic              r_seq;
  logic              r_blank;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_legal;
  logic [3:0]        w_hex;
  seg_class_t        w_class;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= seg_in;
      r_q2 <= r_q1;
    end
  end

  // The candidate keeps tracking the bus while disabled, so counting resumes on the current pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand <= '0;
      r_stab <= '0;
    end else if (r_q2 != r_cand) begin
      r_cand <= r_q2;
      r_stab <= en ? STAB_W'(1) : '0;
    end else if (!en) begin
      r_stab <= '0;
    end else if (r_stab < STAB_MAX) begin
      r_stab <= r_stab + STAB_W'(1);
    end
  end

  assign w_accept = en && (r_stab == STAB_MAX) && (r_cand != r_last);

  seg7_decode u_decode (
    .i_seg   (r_cand),
    .o_legal (w_legal),
    .o_hex   (w_hex)
  );

  always_comb begin
    w_class = CLS_NONE;
    if (w_accept) begin
      if (r_cand == SEG_BLANK) begin
        w_class = CLS_BLANK;
      end else if (w_legal) begin
        w_class = CLS_HEX;
      end else begin
        w_class = CLS_BAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= SEG_BLANK;
      r_have_prev <= 1'b0;
      r_digit     <= '0;
      r_valid     <= 1'b0;
      r_bad       <= 1'b0;
      r_seq       <= 1'b0;
      r_blank     <= 1'b1;
      r_cnt       <= '0;
    end else begin
      r_valid <= 1'b0;
      r_bad   <= 1'b0;
      r_seq   <= 1'b0;
      if (w_accept) begin
        r_last <= r_cand;
      end
      case (w_class)
        CLS_HEX: begin
          r_digit     <= w_hex;
          r_valid     <= 1'b1;
          r_blank     <= 1'b0;
          r_cnt       <= r_cnt + CNT_W'(1);
          r_seq       <= r_have_prev && (w_hex != (r_digit + 4'd1));
          r_have_prev <= 1'b1;
        end
        CLS_BLANK: begin
          r_blank     <= 1'b1;
          r_have_prev <= 1'b0;
        end
        CLS_BAD: begin
          r_bad       <= 1'b1;
          r_blank     <= 1'b0;
          r_have_prev <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign digit       = r_digit;
  assign digit_valid = r_valid;
  assign bad_pattern = r_bad;
  assign seq_err     = r_seq;
  assign blank       = r_blank;
  assign cap_count   = r_cnt;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: latency, counting sequence, sequence errors, glitches, bad/blank, enable and reset.
module tb_seg7_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       en;
  logic [3:0] digit;
  logic       digit_valid;
  logic       bad_pattern;
  logic       seq_err;
  logic       blank;
  logic [7:0] cap_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_capture #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .en          (en),
    .digit       (digit),
    .digit_valid (digit_valid),
    .bad_pattern (bad_pattern),
    .seq_err     (seq_err),
    .blank       (blank),
    .cap_count   (cap_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    en     = 1'b1;
    seg_in = 7'h00;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    en     = 1'b1;
    seg_in = 7'h00;
    step();
    n_tests++;
    if ({digit, digit_valid, bad_pattern, seq_err, blank, cap_count} !== {4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: got digit=%h v=%b bad=%b seq=%b blank=%b cnt=%0d, want 0 0 0 0 1 0",
               digit, digit_valid, bad_pattern, seq_err, blank, cap_count);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_first_digit();
    int first = -1;
    int npulse = 0;
    int nseq = 0;
    seg_in = 7'h3F;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (digit_valid) begin
        npulse++;
        if (first < 0) first = k;
      end
      if (seq_err) nseq++;
    end
    n_tests++;
    if (first !== 7) begin n_fail++; $display("FAIL first_latency: pulse at edge +%0d, want +7", first); end
    n_tests++;
    if (npulse !== 1) begin n_fail++; $display("FAIL first_pulse_count: got %0d, want 1", npulse); end
    n_tests++;
    if ({digit, blank, cap_count} !== {4'h0, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL first_state: digit=%h blank=%b cnt=%0d, want 0 0 1", digit, blank, cap_count);
    end
    n_tests++;
    if (nseq !== 0) begin n_fail++; $display("FAIL first_seq_err: got %0d pulses, want 0", nseq); end
  endtask

  task automatic test_count_sequence();
    int npulse = 0;
    int nseq = 0;
    logic [3:0] want;
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      seg_in = glyph[i % 16];
      want = 4'(i % 16);
      repeat (10) begin
        step();
        if (digit_valid) npulse++;
        if (seq_err) nseq++;
      end
      n_tests++;
      if (digit !== want) begin n_fail++; $display("FAIL count_digit_%0d: got %h, want %h", i, digit, want); end
    end
    n_tests++;
    if (npulse !== 17) begin n_fail++; $display("FAIL count_pulses: got %0d, want 17", npulse); end
    n_tests++;
    if (cap_count !== 8'd17) begin n_fail++; $display("FAIL count_cap: got %0d, want 17", cap_count); end
    n_tests++;
    if (nseq !== 0) begin n_fail++; $display("FAIL count_seq_err: got %0d, want 0", nseq); end
  endtask

  task automatic test_seq_err();
    int coincident = 0;
    int stray = 0;
    seg_in = 7'h06;
    repeat (10) step();
    seg_in = 7'h4F;
    repeat (10) begin
      step();
      if (seq_err && digit_valid) coincident++;
      if (seq_err && !digit_valid) stray++;
    end
    n_tests++;
    if (digit !== 4'h3) begin n_fail++; $display("FAIL seq_digit: got %h, want 3", digit); end
    n_tests++;
    if (coincident !== 1 || stray !== 0) begin
      n_fail++;
      $display("FAIL seq_pulse: coincident=%0d stray=%0d, want 1 0", coincident, stray);
    end
    n_tests++;
    if (cap_count !== 8'd19) begin n_fail++; $display("FAIL seq_cap: got %0d, want 19", cap_count); end
  endtask

  task automatic test_glitch();
    int npulse = 0;
    seg_in = 7'h5B;
    repeat (10) step();
    seg_in = 7'h7F;
    repeat (3) begin
      step();
      if (digit_valid || bad_pattern) npulse++;
    end
    seg_in = 7'h5B;
    repeat (15) begin
      step();
      if (digit_valid || bad_pattern) npulse++;
    end
    n_tests++;
    if (npulse !== 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d, want 0", npulse); end
    n_tests++;
    if (digit !== 4'h2) begin n_fail++; $display("FAIL glitch_digit: got %h, want 2", digit); end
  endtask

  task automatic test_bad_blank();
    int nbad = 0;
    int nvalid = 0;
    int nseq = 0;
    seg_in = 7'h49;
    repeat (10) begin
      step();
      if (bad_pattern) nbad++;
      if (digit_valid) nvalid++;
    end
    n_tests++;
    if (nbad !== 1 || nvalid !== 0) begin
      n_fail++;
      $display("FAIL bad_pulse: bad=%0d valid=%0d, want 1 0", nbad, nvalid);
    end
    n_tests++;
    if (digit !== 4'h2) begin n_fail++; $display("FAIL bad_digit: got %h, want 2", digit); end
    seg_in = 7'h00;
    repeat (10) step();
    n_tests++;
    if (blank !== 1'b1) begin n_fail++; $display("FAIL blank_level: got %b, want 1", blank); end
    nvalid = 0;
    seg_in = 7'h66;
    repeat (10) begin
      step();
      if (digit_valid) nvalid++;
      if (seq_err) nseq++;
    end
    n_tests++;
    if ({digit, blank} !== {4'h4, 1'b0} || nvalid !== 1 || nseq !== 0) begin
      n_fail++;
      $display("FAIL after_blank: digit=%h blank=%b valid=%0d seq=%0d, want 4 0 1 0", digit, blank, nvalid, nseq);
    end
  endtask

  task automatic test_enable_and_reset();
    int npulse = 0;
    int first = -1;
    int nseq = 0;
    en = 1'b0;
    seg_in = 7'h3F;
    repeat (5) begin
      step();
      if (digit_valid || bad_pattern) npulse++;
    end
    seg_in = 7'h06;
    repeat (10) begin
      step();
      if (digit_valid || bad_pattern) npulse++;
    end
    n_tests++;
    if (npulse !== 0) begin n_fail++; $display("FAIL en_low_pulses: got %0d, want 0", npulse); end
    en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (digit_valid && first < 0) first = k;
    end
    n_tests++;
    if (first !== 5) begin n_fail++; $display("FAIL en_latency: pulse at edge +%0d, want +5", first); end
    n_tests++;
    if ({digit, cap_count} !== {4'h1, 8'd22}) begin
      n_fail++;
      $display("FAIL en_state: digit=%h cnt=%0d, want 1 22", digit, cap_count);
    end
    seg_in = 7'h07;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({digit, digit_valid, bad_pattern, seq_err, blank, cap_count} !== {4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL async_reset: got digit=%h v=%b bad=%b seq=%b blank=%b cnt=%0d, want 0 0 0 0 1 0",
               digit, digit_valid, bad_pattern, seq_err, blank, cap_count);
    end
    seg_in = 7'h4F;
    step();
    step();
    rst_n = 1'b1;
    npulse = 0;
    repeat (12) begin
      step();
      if (digit_valid) npulse++;
      if (seq_err) nseq++;
    end
    n_tests++;
    if ({digit, cap_count} !== {4'h3, 8'd1} || npulse !== 1 || nseq !== 0) begin
      n_fail++;
      $display("FAIL post_reset: digit=%h cnt=%0d valid=%0d seq=%0d, want 3 1 1 0", digit, cap_count, npulse, nseq);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    seg_in = 7'h00;
    test_reset();
    test_first_digit();
    test_count_sequence();
    test_seq_err();
    test_glitch();
    test_bad_blank();
    test_enable_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
